// File: rtl/rcon_seq_gen.sv
// AES round-constant generator: emits Rcon[1..N] one word per valid/ready transfer,
// computing each byte with GF(2^8) xtime. N is chosen from the key length at start.
module rcon_seq_gen #(
  parameter int          WORD_W   = 32,
  parameter bit          RCON_MSB = 1'b0,
  parameter logic [7:0]  POLY     = 8'h1B
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [1:0]        key_len,
  input  logic              rcon_ready,
  output logic              rcon_valid,
  output logic [WORD_W-1:0] rcon_word,
  output logic [3:0]        rcon_idx,
  output logic              rcon_last,
  output logic              busy,
  output logic              done
);

  localparam int LANES = WORD_W / 8;
  localparam int RLANE = RCON_MSB ? LANES - 1 : 0;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t     state_reg, state_next;
  logic [7:0] byte_reg, byte_next;
  logic [3:0] idx_reg, idx_next;
  logic [3:0] limit_reg, limit_next;
  logic       xfer;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? POLY : 8'h00);
  endfunction

  assign xfer = (state_reg == RUN) && rcon_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      byte_reg  <= 8'h00;
      idx_reg   <= 4'd0;
      limit_reg <= 4'd10;
    end else begin
      state_reg <= state_next;
      byte_reg  <= byte_next;
      idx_reg   <= idx_next;
      limit_reg <= limit_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    byte_next  = byte_reg;
    idx_next   = idx_reg;
    limit_next = limit_reg;
    case (state_reg)
      IDLE: begin
        if (start) begin
          state_next = RUN;
          byte_next  = 8'h01;
          idx_next   = 4'd1;
          case (key_len)
            2'b01:   limit_next = 4'd8;
            2'b10:   limit_next = 4'd7;
            default: limit_next = 4'd10;
          endcase
        end
      end
      RUN: begin
        if (xfer) begin
          if (idx_reg == limit_reg) begin
            state_next = DONE;
            byte_next  = 8'h00;
            idx_next   = 4'd0;
          end else begin
            byte_next = xtime(byte_reg);
            idx_next  = idx_reg + 4'd1;
          end
        end
      end
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
    // Abort overrides everything, including a same-cycle start or final transfer.
    if (abort) begin
      state_next = IDLE;
      byte_next  = 8'h00;
      idx_next   = 4'd0;
    end
  end

  // byte_reg is forced to zero outside RUN, so the word is zero whenever invalid.
  generate
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
      assign rcon_word[gi*8 +: 8] = (gi == RLANE) ? byte_reg : 8'h00;
    end
  endgenerate

  assign rcon_valid = (state_reg == RUN);
  assign busy       = (state_reg == RUN);
  assign done       = (state_reg == DONE);
  assign rcon_idx   = idx_reg;
  assign rcon_last  = rcon_valid && (idx_reg == limit_reg);

endmodule

// File: tb/tb_rcon_seq_gen.sv
// Directed bench for rcon_seq_gen: LSB- and MSB-placed instances share one stimulus.
module tb_rcon_seq_gen;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [1:0]  key_len = 2'b00;
  logic        rcon_ready = 1'b0;
  logic        rcon_valid, rcon_last, busy, done;
  logic [31:0] rcon_word;
  logic [3:0]  rcon_idx;
  logic        m_valid, m_last, m_busy, m_done;
  logic [31:0] m_word;
  logic [3:0]  m_idx;

  int checks = 0;
  int errors = 0;

  logic [7:0] exp_b [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                             8'h20, 8'h40, 8'h80, 8'h1B, 8'h36};

  always #5 clk = ~clk;

  rcon_seq_gen #(.WORD_W(32), .RCON_MSB(1'b0), .POLY(8'h1B)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .key_len(key_len),
    .rcon_ready(rcon_ready), .rcon_valid(rcon_valid), .rcon_word(rcon_word),
    .rcon_idx(rcon_idx), .rcon_last(rcon_last), .busy(busy), .done(done)
  );

  rcon_seq_gen #(.WORD_W(32), .RCON_MSB(1'b1), .POLY(8'h1B)) dut_msb (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .key_len(key_len),
    .rcon_ready(rcon_ready), .rcon_valid(m_valid), .rcon_word(m_word),
    .rcon_idx(m_idx), .rcon_last(m_last), .busy(m_busy), .done(m_done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_valid"}, {31'd0, rcon_valid}, 32'd0);
    chk({tag, "_word"}, rcon_word, 32'd0);
    chk({tag, "_idx"}, {28'd0, rcon_idx}, 32'd0);
    chk({tag, "_last"}, {31'd0, rcon_last}, 32'd0);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
  endtask

  // Full sequence with ready tied high; optionally hold start during the done cycle.
  task automatic run_seq(input logic [1:0] kl, input int n, input bit start_in_done);
    key_len = kl;
    rcon_ready = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < n; i++) begin
      chk($sformatf("seq%0d_valid_i%0d", kl, i + 1), {31'd0, rcon_valid}, 32'd1);
      chk($sformatf("seq%0d_word_i%0d", kl, i + 1), rcon_word, {24'd0, exp_b[i]});
      chk($sformatf("seq%0d_mword_i%0d", kl, i + 1), m_word, {exp_b[i], 24'd0});
      chk($sformatf("seq%0d_idx_i%0d", kl, i + 1), {28'd0, rcon_idx}, i + 1);
      chk($sformatf("seq%0d_last_i%0d", kl, i + 1), {31'd0, rcon_last}, (i == n - 1) ? 32'd1 : 32'd0);
      chk($sformatf("seq%0d_busy_i%0d", kl, i + 1), {31'd0, busy}, 32'd1);
      step();
    end
    chk($sformatf("seq%0d_done", kl), {31'd0, done}, 32'd1);
    chk_idle($sformatf("seq%0d_after", kl));
    if (start_in_done) start = 1'b1;
    step();
    start = 1'b0;
    chk($sformatf("seq%0d_done_pulse", kl), {31'd0, done}, 32'd0);
    chk_idle($sformatf("seq%0d_idle", kl));
    rcon_ready = 1'b0;
  endtask

  initial begin
    int  cnt;
    bit  fin;
    logic [31:0] held_word;

    // Reset state
    #1;
    chk_idle("rst");
    chk("rst_done", {31'd0, done}, 32'd0);
    step();
    rst = 1'b0;
    rcon_ready = 1'b1;
    step();
    chk_idle("ready_idle");

    // All key lengths; AES-256 run also checks start ignored in DONE
    run_seq(2'b00, 10, 1'b0);
    run_seq(2'b01, 8, 1'b0);
    run_seq(2'b10, 7, 1'b1);
    run_seq(2'b11, 10, 1'b0);

    // Random backpressure
    key_len = 2'b00;
    rcon_ready = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    cnt = 0;
    fin = 1'b0;
    held_word = 32'd0;
    for (int c = 0; c < 300 && !fin; c++) begin
      if (done) begin
        fin = 1'b1;
      end else begin
        rcon_ready = 1'($urandom_range(0, 1));
        if (rcon_valid) begin
          chk($sformatf("stall_word_c%0d", c), rcon_word, (cnt < 10) ? {24'd0, exp_b[cnt]} : 32'hxxxxxxxx);
          chk($sformatf("stall_idx_c%0d", c), {28'd0, rcon_idx}, cnt + 1);
          if (rcon_ready) cnt++;
        end
        step();
      end
    end
    chk("stall_finished", {31'd0, fin}, 32'd1);
    chk("stall_count", cnt, 32'd10);
    step();
    chk_idle("stall_idle");

    // Abort together with transfer of idx 5
    rcon_ready = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (4) step();
    chk("abort_pre_idx", {28'd0, rcon_idx}, 32'd5);
    chk("abort_pre_word", rcon_word, 32'h10);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk_idle("abort");
    chk("abort_done", {31'd0, done}, 32'd0);
    step();
    chk("abort_done2", {31'd0, done}, 32'd0);
    chk("abort_busy2", {31'd0, busy}, 32'd0);

    // Abort beats a same-cycle start
    start = 1'b1;
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("abort_start_busy", {31'd0, busy}, 32'd0);
    step();
    start = 1'b0;
    chk("restart_word", rcon_word, 32'h01);
    chk("restart_idx", {28'd0, rcon_idx}, 32'd1);
    abort = 1'b1;
    step();
    abort = 1'b0;

    // Start in RUN ignored; key_len change during RUN ignored
    key_len = 2'b01;
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (2) step();
    rcon_ready = 1'b0;
    start = 1'b1;
    key_len = 2'b10;
    step();
    start = 1'b0;
    chk("run_start_idx", {28'd0, rcon_idx}, 32'd3);
    chk("run_start_word", rcon_word, 32'h04);
    step();
    chk("hold_word", rcon_word, 32'h04);
    rcon_ready = 1'b1;
    repeat (4) step();
    chk("keylen_idx7_last", {31'd0, rcon_last}, 32'd0);
    step();
    chk("keylen_idx8_word", rcon_word, 32'h80);
    chk("keylen_idx8_last", {31'd0, rcon_last}, 32'd1);
    step();
    chk("keylen_done", {31'd0, done}, 32'd1);
    step();

    // Asynchronous reset mid-cycle at idx 9
    key_len = 2'b00;
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (8) step();
    chk("prerst_word", rcon_word, 32'h1B);
    chk("prerst_mword", m_word, 32'h1B000000);
    #3;
    rst = 1'b1;
    #1;
    chk_idle("async_rst");
    chk("async_rst_mword", m_word, 32'd0);
    #1;
    rst = 1'b0;
    step();
    step();
    chk_idle("post_rst");
    chk("post_rst_done", {31'd0, done}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
